// File: rtl/clock_ctrl.sv
// CPU clock generator: debounced front-panel buttons drive a RUN/STOP/HALT controller
// that produces a glitch-free divided clock, single-step pulses and a rise strobe.
module clock_ctrl #(
    parameter int                          CNT_W        = 32,
    parameter int                          NUM_SPEEDS   = 4,
    parameter logic [NUM_SPEEDS*CNT_W-1:0] HALF_PERIODS = {32'd12500, 32'd125000, 32'd1250000, 32'd12500000},
    parameter int                          DEBOUNCE     = 16,
    parameter int                          STEP_HIGH    = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst,
    input  logic                                                 clk_start_stop_i,
    input  logic                                                 clk_step_i,
    input  logic                                                 clk_speed_i,
    input  logic                                                 hlt_i,
    output logic                                                 clk,
    output logic                                                 clk_en,
    output logic [1:0]                                           state_o,
    output logic [((NUM_SPEEDS > 2) ? $clog2(NUM_SPEEDS) : 1)-1:0] speed_o
);

    localparam int SPD_W = (NUM_SPEEDS > 2) ? $clog2(NUM_SPEEDS) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int ST_W  = $clog2(STEP_HIGH + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STOP = 2'd1,
        HALT = 2'd2
    } state_e;

    // Button lanes: bit 0 start/stop, bit 1 step, bit 2 speed.
    logic [2:0]      meta_q;
    logic [2:0]      sync_q;
    logic [2:0]      deb_q;
    logic [2:0]      ev_q;
    logic [DB_W-1:0] dcnt_q [3];

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            deb_q  <= '0;
            ev_q   <= '0;
            for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
        end else begin
            meta_q <= {clk_speed_i, clk_step_i, clk_start_stop_i};
            sync_q <= meta_q;
            for (int i = 0; i < 3; i++) begin
                ev_q[i] <= 1'b0;
                if (sync_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
                    deb_q[i]  <= sync_q[i];
                    dcnt_q[i] <= '0;
                    ev_q[i]   <= sync_q[i];
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic             ss_ev;
    logic             step_ev;
    logic             spd_ev;
    state_e           state_q;
    logic             clk_q;
    logic             en_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ST_W-1:0]  scnt_q;
    logic [SPD_W-1:0] speed_q;
    logic [SPD_W-1:0] speed_d;
    logic             stop_pend_q;
    logic             start_pend_q;
    logic             step_act_q;
    logic             hlt_pend_q;
    logic [CNT_W-1:0] half;
    logic             at_end;
    logic             step_end;
    logic             hlt_seen;

    assign {spd_ev, step_ev, ss_ev} = ev_q;
    assign half     = HALF_PERIODS[int'(speed_q)*CNT_W +: CNT_W];
    // >= rather than == so a switch to a shorter half-period ends the phase at once.
    assign at_end   = (cnt_q >= half - CNT_W'(1));
    assign step_end = (scnt_q == ST_W'(STEP_HIGH - 1));
    assign hlt_seen = hlt_pend_q | hlt_i;
    assign speed_d  = (speed_q == SPD_W'(NUM_SPEEDS - 1)) ? '0 : speed_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            clk_q        <= 1'b0;
            en_q         <= 1'b0;
            cnt_q        <= '0;
            scnt_q       <= '0;
            speed_q      <= '0;
            stop_pend_q  <= 1'b0;
            start_pend_q <= 1'b0;
            step_act_q   <= 1'b0;
            hlt_pend_q   <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (spd_ev) speed_q <= speed_d;
            if (clk_q && hlt_i) hlt_pend_q <= 1'b1;
            case (state_q)
                RUN: begin
                    if (ss_ev && !clk_q) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                    end else begin
                        if (ss_ev) stop_pend_q <= 1'b1;
                        if (at_end) begin
                            cnt_q <= '0;
                            clk_q <= !clk_q;
                            en_q  <= !clk_q;
                            if (clk_q && hlt_seen) begin
                                state_q <= HALT;
                            end else if (clk_q && (stop_pend_q || ss_ev)) begin
                                state_q     <= STOP;
                                stop_pend_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (step_act_q) begin
                        if (ss_ev) start_pend_q <= 1'b1;
                        if (step_end) begin
                            clk_q        <= 1'b0;
                            step_act_q   <= 1'b0;
                            scnt_q       <= '0;
                            start_pend_q <= 1'b0;
                            if (hlt_seen) begin
                                state_q <= HALT;
                            end else if (start_pend_q || ss_ev) begin
                                state_q <= RUN;
                                cnt_q   <= '0;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end else if (ss_ev) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else if (step_ev) begin
                        clk_q      <= 1'b1;
                        en_q       <= 1'b1;
                        step_act_q <= 1'b1;
                        scnt_q     <= '0;
                    end
                end
                default: begin
                    clk_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk     = clk_q;
    assign clk_en  = en_q;
    assign state_o = state_q;
    assign speed_o = speed_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: expected clock phases are queued as stimulus is applied and
// checked as each phase of the generated clock completes.
module tb_clock_ctrl;

    logic       clk_i   = 1'b0;
    logic       rst     = 1'b1;
    logic       ss_i    = 1'b0;
    logic       step_i  = 1'b0;
    logic       spd_i   = 1'b0;
    logic       hlt_i   = 1'b0;
    logic       clk;
    logic       clk_en;
    logic [1:0] state_o;
    logic [1:0] speed_o;

    clock_ctrl #(
        .CNT_W        (8),
        .NUM_SPEEDS   (4),
        .HALF_PERIODS ({8'd1, 8'd2, 8'd3, 8'd4}),
        .DEBOUNCE     (3),
        .STEP_HIGH    (2)
    ) dut (
        .clk_i            (clk_i),
        .rst              (rst),
        .clk_start_stop_i (ss_i),
        .clk_step_i       (step_i),
        .clk_speed_i      (spd_i),
        .hlt_i            (hlt_i),
        .clk              (clk),
        .clk_en           (clk_en),
        .state_o          (state_o),
        .speed_o          (speed_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic lvl;
        int   len;
    } phase_t;

    phase_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     plen   = 0;
    int     rises  = 0;
    int     r      = 0;
    logic   clk_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_phase(input logic lvl, input int len);
        phase_t p;
        p.lvl = lvl;
        p.len = len;
        exp_q.push_back(p);
    endtask

    // One clk_i cycle; samples 1 time unit after the edge and scores completed phases.
    task automatic tick();
        phase_t p;
        @(posedge clk_i);
        #1;
        if (clk_en === 1'b1 || (clk === 1'b1 && clk_prev === 1'b0))
            check("clk_en", clk_en, (clk === 1'b1 && clk_prev === 1'b0));
        if (clk !== clk_prev) begin
            if (clk === 1'b1) rises++;
            if (exp_q.size() != 0) begin
                p = exp_q.pop_front();
                check("phase_lvl", clk_prev, p.lvl);
                if (p.len >= 0) check("phase_len", plen, p.len);
            end
            plen = 1;
        end else begin
            plen++;
        end
        clk_prev = clk;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic ticks_to_rise(input string tag, input int budget, input int exp_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (clk !== 1'b1 && n < budget);
        check(tag, n, exp_n);
    endtask

    // m = {speed, step, start_stop}; held long enough to pass the debouncer.
    task automatic press(input logic [2:0] m);
        {spd_i, step_i, ss_i} = m;
        repeat (5) tick();
        {spd_i, step_i, ss_i} = 3'b000;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_clk", clk, 0);
        check("rst_clk_en", clk_en, 0);
        check("rst_state", state_o, 0);
        check("rst_speed", speed_o, 0);
        rst = 1'b0;
        ticks_to_rise("first_rise", 20, 4);
        check("run_state", state_o, 0);

        repeat (3) begin
            expect_phase(1, 4);
            expect_phase(0, 4);
        end
        drain("run_spd0", 40);

        // Speed presses, each issued on a rising edge of clk.
        expect_phase(1, 4); expect_phase(0, 3); expect_phase(1, 3); expect_phase(0, 3);
        press(3'b100);
        drain("spd_0to1", 40);
        check("speed_1", speed_o, 1);
        expect_phase(1, 3); expect_phase(0, 3); expect_phase(1, 2); expect_phase(0, 2);
        press(3'b100);
        drain("spd_1to2", 40);
        check("speed_2", speed_o, 2);
        expect_phase(1, 2); expect_phase(0, 2); expect_phase(1, 2);
        expect_phase(0, 1); expect_phase(1, 1); expect_phase(0, 1);
        press(3'b100);
        drain("spd_2to3", 40);
        check("speed_3", speed_o, 3);
        repeat (3) begin
            expect_phase(1, 1);
            expect_phase(0, 1);
        end
        expect_phase(1, 4); expect_phase(0, 4);
        press(3'b100);
        drain("spd_3to0", 40);
        check("speed_0", speed_o, 0);

        // Stop requested while clk is high: the high phase runs to full length.
        expect_phase(1, 4); expect_phase(0, 4); expect_phase(1, 4);
        repeat (4) tick();
        press(3'b001);
        check("stop_pend_state", state_o, 0);
        check("stop_pend_clk", clk, 1);
        drain("stop_high", 20);
        check("stop_state", state_o, 1);
        r = rises;
        repeat (10) tick();
        check("stop_idle_clk", clk, 0);
        check("stop_idle_rises", rises - r, 0);

        // Single step from STOP.
        r = rises;
        expect_phase(0, -1); expect_phase(1, 2);
        press(3'b010);
        drain("step_pulse", 20);
        check("step_state", state_o, 1);
        check("step_rises", rises - r, 1);

        // Start/stop arriving one cycle into a step pulse: pulse completes, then RUN.
        expect_phase(0, -1); expect_phase(1, 2); expect_phase(0, 4);
        expect_phase(1, 4); expect_phase(0, 4);
        step_i = 1'b1;
        tick();
        ss_i = 1'b1;
        repeat (4) tick();
        step_i = 1'b0;
        tick();
        ss_i = 1'b0;
        drain("step_then_start", 40);
        check("step_start_state", state_o, 0);

        // Stop requested while clk is low takes effect immediately.
        expect_phase(1, 4);
        press(3'b001);
        tick();
        check("stop_low_state", state_o, 1);
        drain("stop_low", 5);
        r = rises;
        repeat (10) tick();
        check("stop_low_clk", clk, 0);
        check("stop_low_rises", rises - r, 0);

        // Two-cycle glitch on the speed button is filtered.
        spd_i = 1'b1;
        repeat (2) tick();
        spd_i = 1'b0;
        repeat (8) tick();
        check("glitch_speed", speed_o, 0);

        // Start/stop and step together: start wins, no step pulse.
        press(3'b011);
        tick();
        check("both_state", state_o, 0);
        check("both_clk", clk, 0);
        ticks_to_rise("both_rise", 20, 4);
        expect_phase(1, 4); expect_phase(0, 4);
        drain("both_run", 20);

        // hlt_i during a low phase is not sampled.
        expect_phase(1, 4); expect_phase(0, 4); expect_phase(1, 4); expect_phase(0, 4);
        repeat (4) tick();
        hlt_i = 1'b1;
        repeat (3) tick();
        hlt_i = 1'b0;
        drain("hlt_low", 30);
        check("hlt_low_state", state_o, 0);

        // hlt_i during a high phase: clk falls on schedule, then HALT.
        expect_phase(1, 4);
        hlt_i = 1'b1;
        tick();
        hlt_i = 1'b0;
        drain("hlt_high", 10);
        check("halt_state", state_o, 2);
        r = rises;
        repeat (8) tick();
        check("halt_clk", clk, 0);
        press(3'b001);
        repeat (10) tick();
        check("halt_ss_state", state_o, 2);
        check("halt_ss_clk", clk, 0);
        press(3'b010);
        repeat (10) tick();
        check("halt_step_clk", clk, 0);
        check("halt_rises", rises - r, 0);
        press(3'b100);
        repeat (3) tick();
        check("halt_speed", speed_o, 1);

        // Reset leaves HALT; reset during a high phase drops clk at once.
        rst = 1'b1;
        repeat (2) tick();
        check("rst2_speed", speed_o, 0);
        check("rst2_state", state_o, 0);
        rst = 1'b0;
        ticks_to_rise("rise_after_rst", 20, 4);
        tick();
        check("pre_rst_clk", clk, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_clk", clk, 0);
        check("rst_mid_state", state_o, 0);

        // Button held through reset yields exactly one event.
        spd_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (12) tick();
        check("held_speed", speed_o, 1);
        spd_i = 1'b0;
        repeat (10) tick();
        check("held_once", speed_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
